mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between two requesters: port 0 is the multicycle core's instruction/data memory interface, port 1 is a DMA/debug loader.
- Each access runs as a request/acknowledge transaction.
- A three-state FSM sequences the memory for a fixed number of cycles per access.
- Contended requests are granted round-robin so neither port starves.

Parameters:
- ADDR_W, 32, address width of requests and memory.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles the memory needs with address/control held stable (legal range 1 to 15).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 request; held high until ack0.
- we0  in  1  port 0 write enable (1 = write, 0 = read).
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- req1  in  1  port 1 request.
- we1  in  1  port 1 write enable.
- addr1  in  ADDR_W  port 1 address.
- wdata1  in  DATA_W  port 1 write data.
- ack0  out  1  one-cycle completion pulse for port 0.
- ack1  out  1  one-cycle completion pulse for port 1.
- rdata  out  DATA_W  read data, valid when ack0 or ack1 is high for a read.
- busy  out  1  high whenever the FSM is not IDLE.
- owner  out  1  port currently being served; meaningful only while busy.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, all outputs 0, rdata = 0, cnt = 0.
  - last-granted register = 1, so port 0 wins the first tie.
  - Reset during ACCESS aborts the access immediately: mem_we/mem_re fall with reset, no ack is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If exactly one req is high, grant that port.
  - If both are high, grant the port not equal to the last-granted register.
  - On grant, latch we/addr/wdata of the winner into internal registers, set owner, set cnt = MEM_LAT-1, go to ACCESS.
  - With no req, stay in IDLE.
  - mem_re = mem_we = 0 in IDLE.
- ACCESS:
  - mem_addr/mem_wdata driven from the latched registers.
  - mem_we = latched we; mem_re = ~latched we; both constant for all MEM_LAT cycles.
  - cnt decrements each cycle.
  - On the cycle with cnt == 0: for a read, capture mem_rdata into rdata; go to RESP.
  - Port inputs changing during ACCESS have no effect.
- RESP:
  - ack[owner] = 1 for exactly one cycle; mem strobes = 0.
  - last-granted <= owner; go to IDLE.
  - Writes leave rdata unchanged.
  - rdata holds its value until the next read completes.
- Handshake:
  - A requester keeps req and its fields stable until it samples ack, then drops req at that same clock edge.
  - A req still high in the IDLE cycle after RESP is a new transaction.
  - The losing port of a tie keeps req high and is granted in the next IDLE cycle.
- Latency: uncontended access sampled in IDLE at cycle t, ACCESS in cycles t+1..t+MEM_LAT, ack in cycle t+MEM_LAT+1. Minimum spacing between grants is MEM_LAT+2 cycles.
- busy = (state != IDLE). ack0 and ack1 are never high together.
- mem_addr/mem_wdata hold their last latched value outside ACCESS; this value is don't-care for memory.

Test Plan:
- Reset, then single read: req0=1, we0=0, addr0=0x10, memory word 0x10 = 0xDEADBEEF, MEM_LAT=2 -> mem_re high 2 cycles, ack0 high on the 3rd cycle after the request cycle, rdata = 0xDEADBEEF, ack1 = 0.
- Single write: req1=1, we1=1, addr1=0x20, wdata1=0x12345678 -> mem_we high 2 cycles with mem_addr=0x20, ack1 pulses once, memory word 0x20 = 0x12345678, rdata unchanged.
- Tie after reset: req0 and req1 both high from the same cycle -> port 0 served first (ack0), port 1 granted in the next IDLE cycle (ack1); order of acks is 0, 1.
- Fairness: both ports hold continuous back-to-back requests for 6 transactions -> acks alternate 0, 1, 0, 1, 0, 1, with MEM_LAT+2 cycles between consecutive acks.
- Mid-access input change: during ACCESS, addr0 changes 0x10 -> 0x40 -> mem_addr stays 0x10 through the access, and the returned data is from 0x10.
- Reset mid-operation: assert rst low in the 2nd ACCESS cycle of a write -> mem_we drops immediately, no ack. After release, state is IDLE and busy = 0. A pending tie is granted to port 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the shared memory port of mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              owner;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata,
    output ack0, ack1, rdata, busy, owner,
    output mem_addr, mem_wdata, mem_re, mem_we
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata,
    input  ack0, ack1, rdata, busy, owner,
    input  mem_addr, mem_wdata, mem_re, mem_we
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between two requesters.
// Each grant holds the memory for MEM_LAT cycles, then acks the owner for one cycle.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t            state_reg;
  logic [3:0]        cnt_reg;
  logic              last_reg;
  logic              owner_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              ack0_reg;
  logic              ack1_reg;
  logic              mem_re_reg;
  logic              mem_we_reg;

  logic              grant_any;
  logic              grant_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // On a tie the port that was not served last wins.
  always_comb begin
    grant_any  = bus.req0 | bus.req1;
    grant_port = bus.req1 & (~bus.req0 | ~last_reg);
    sel_we     = grant_port ? bus.we1    : bus.we0;
    sel_addr   = grant_port ? bus.addr1  : bus.addr0;
    sel_wdata  = grant_port ? bus.wdata1 : bus.wdata0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      last_reg   <= 1'b1;
      owner_reg  <= 1'b0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      ack0_reg   <= 1'b0;
      ack1_reg   <= 1'b0;
      mem_re_reg <= 1'b0;
      mem_we_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            owner_reg  <= grant_port;
            we_reg     <= sel_we;
            addr_reg   <= sel_addr;
            wdata_reg  <= sel_wdata;
            cnt_reg    <= CNT_INIT;
            mem_we_reg <= sel_we;
            mem_re_reg <= ~sel_we;
            state_reg  <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_reg == 4'd0) begin
            if (!we_reg) rdata_reg <= bus.mem_rdata;
            mem_re_reg <= 1'b0;
            mem_we_reg <= 1'b0;
            ack0_reg   <= ~owner_reg;
            ack1_reg   <= owner_reg;
            state_reg  <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          ack0_reg  <= 1'b0;
          ack1_reg  <= 1'b0;
          last_reg  <= owner_reg;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.ack0      = ack0_reg;
  assign bus.ack1      = ack1_reg;
  assign bus.rdata     = rdata_reg;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.owner     = owner_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.mem_re    = mem_re_reg;
  assign bus.mem_we    = mem_we_reg;

endmodule
